// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared state encodings and timebase defaults for the PWM update scheduler
package pwm_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STOP  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_START = 2'd3;

  localparam logic [31:0] DEF_TIMEBASE_ADDR = 32'h43C0_0000;
  localparam logic [31:0] DEF_STOP_WORD     = 32'h0011_1108;
  localparam logic [31:0] DEF_RUN_WORD      = 32'h0011_1128;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pwm_update_fifo.sv
// rtl/pwm_update_fifo.sv - first-word-fall-through FIFO holding {dest,data} PWM register writes
module pwm_update_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// rtl/pwm_update_scheduler.sv - releases buffered PWM writes as a burst in the window after carrier sync
// Macro PWM_SCHED_TIMEBASE_HOLD_EN wraps each burst in timebase stop/run writes.
module pwm_update_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
  parameter logic [DEST_WIDTH-1:0] TIMEBASE_ADDR = DEST_WIDTH'(DEF_TIMEBASE_ADDR),
  parameter logic [DATA_WIDTH-1:0] STOP_WORD     = DATA_WIDTH'(DEF_STOP_WORD),
  parameter logic [DATA_WIDTH-1:0] RUN_WORD      = DATA_WIDTH'(DEF_RUN_WORD),
`endif
  parameter int FIFO_DEPTH    = 16,
  parameter int WINDOW_CYCLES = 40,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [LW-1:0]         fifo_level,
  output logic [15:0]           overrun_count
);

  localparam int WW = $clog2(WINDOW_CYCLES + 1) + 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW_CYCLES);

  logic [1:0]                       state;
  logic [LW-1:0]                    burst_len;
  logic [WW-1:0]                    win_cnt;
  logic [DEST_WIDTH+DATA_WIDTH-1:0] head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             beat_done;
  logic                             fifo_pop;
  logic                             start_burst;
  logic                             last_beat;
  logic                             window_shut;

  assign beat_done   = out_valid && out_ready;
  assign fifo_pop    = beat_done && (state == ST_ISSUE);
  assign start_burst = (state == ST_IDLE) && sync && enable && !fifo_empty;
  assign last_beat   = (burst_len == LW'(1));
  // A beat accepted here would let the next one start at or past the window limit.
  assign window_shut = (win_cnt >= WIN_LAST);
  assign in_ready    = !fifo_full;
  assign busy        = (state != ST_IDLE);

  pwm_update_fifo #(
    .WIDTH (DEST_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid),
    .wr_data ({in_dest, in_data}),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    out_dest = head[DATA_WIDTH +: DEST_WIDTH];
    out_data = head[DATA_WIDTH-1:0];
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
    if (state == ST_STOP) begin
      out_dest = TIMEBASE_ADDR;
      out_data = STOP_WORD;
    end else if (state == ST_START) begin
      out_dest = TIMEBASE_ADDR;
      out_data = RUN_WORD;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      burst_len     <= '0;
      win_cnt       <= '0;
      overrun_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_burst) begin
            burst_len <= fifo_level;
            win_cnt   <= '0;
            out_valid <= 1'b1;
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
            state     <= ST_STOP;
`else
            state     <= ST_ISSUE;
`endif
          end
        end
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
        ST_STOP: begin
          if (beat_done) begin
            state   <= ST_ISSUE;
            win_cnt <= '0;
          end
        end
`endif
        ST_ISSUE: begin
          if (win_cnt != WIN_MAX) win_cnt <= win_cnt + 1'b1;
          if (beat_done) begin
            burst_len <= burst_len - 1'b1;
            if (last_beat || window_shut) begin
              if (!last_beat) overrun_count <= sat_inc16(overrun_count);
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
              state     <= ST_START;
`else
              state     <= ST_IDLE;
              out_valid <= 1'b0;
`endif
            end
          end
        end
`ifdef PWM_SCHED_TIMEBASE_HOLD_EN
        ST_START: begin
          if (beat_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
